alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage consumer of the 4-bit ALUControlD code produced by the ALU control decoder.
//  Accepts operands and control code via a valid/ready handshake and evaluates the operation.
//  Holds results in a 2-entry output FIFO (skid buffer) and presents them to the memory stage.
//  Sits between the decode/issue stage and the EX/MEM boundary of each superscalar lane.
// PARAMETERS
//  WIDTH     32   operand/result width in bits (>=17)
//  REGW      5    width of destination-register tag carried alongside the result
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      asynchronous, active-high reset
//  FlushE       in   1      synchronous flush: discard all buffered results
//  ValidD       in   1      issue side: operands/control valid
//  ReadyD       out  1      unit can accept an operation this cycle
//  ALUControlD  in   4      operation code (table below)
//  SrcAD        in   WIDTH  operand A
//  SrcBD        in   WIDTH  operand B
//  WriteRegD    in   REGW   destination tag, passed through unchanged
//  ValidE       out  1      head result valid
//  ReadyE       in   1      downstream accepts head result
//  ResultE      out  WIDTH  head result
//  ZeroE        out  1      head result == 0
//  WriteRegE    out  REGW   head destination tag
//  IllegalE     out  1      head entry carried an undefined ALUControl code
//  OverflowE    out  1      head entry signed add/sub overflow (see CONFIGURATION)
// BEHAVIOUR
//  Op table: 0000 A&B | 0001 A|B | 0010 A+B | 0011 signed A<B ->1/0 | 0100 A^B | 0101 ~(A|B)
//            0110 A-B | 0111 B<<16 (lui) | 1000 unsigned A<B ->1/0 | others: result 0, IllegalE=1.
//  Arithmetic mod 2^WIDTH; slt/sltu results zero-extended to WIDTH.
//  Push = ValidD & ReadyD; pop = ValidE & ReadyE. Result computed combinationally, written at push edge.
//  Latency: op pushed at edge N appears at head (ValidE=1) from edge N if FIFO empty -> visible cycle N+1.
//  Ordering strictly FIFO; entries never reordered or duplicated.
//  State: occupancy Count in {0,1,2}, write/read pointers (1 bit each, wrap 1->0).
//  ReadyD = (Count != 2); depends on registered state only, never on ReadyE (no comb path D<->E).
//  ValidE = (Count != 0). Head outputs (ResultE, ZeroE, WriteRegE, IllegalE, OverflowE) stable while ValidE & !ReadyE.
//  Simultaneous push+pop at Count=1: Count stays 1, head advances to new entry.
//  Push+pop at Count=0 impossible (ValidE=0); Count=2 blocks push.
//  FlushE: highest priority; Count->0, pointers->0, same-cycle push and pop both discarded.
//  reset (any time, incl. mid-transfer): Count=0, pointers=0, storage cleared to 0;
//  outputs: ReadyD=1, ValidE=0, ResultE=0, ZeroE=1, WriteRegE=0, IllegalE=0, OverflowE=0.
//  When ValidE=0, head outputs show the storage at read pointer (don't-care to consumers).
// CONFIGURATION
//  ALU_OVERFLOW_EN defined: for codes 0010/0110 stores signed overflow bit
//   (A,B same sign & result sign differs for add; A,B differ & result sign != A for sub); OverflowE
//   reports it for head entry; 0 for all other codes.
//  ALU_OVERFLOW_EN undefined: no overflow storage; OverflowE tied to 0.
// TESTING
//  Reset: assert reset mid-stream with Count=2 -> next cycle ValidE=0, ReadyD=1, ResultE=0, ZeroE=1.
//  Ops: each code with A=0xFFFF_FFF0,B=0x0000_0010, ReadyE=1 -> and 0x10, or 0xFFFF_FFF0, add 0,
//   slt 1, xor 0xFFFF_FFE0, nor 0x0F, sub 0xFFFF_FFE0, lui 0x0010_0000, sltu 0; code 1111 -> 0, IllegalE=1.
//  Backpressure: ReadyE=0, push 3 ops back-to-back -> ReadyD drops after 2nd; 3rd held; release ReadyE
//   -> results emerge in order, ReadyD returns 1 cycle after first pop.
//  Streaming: ValidD=1, ReadyE=1 for 20 cycles -> one result per cycle, Count never exceeds 1.
//  Flush: Count=2, FlushE with ValidD=1 and ReadyE=1 -> next cycle ValidE=0, flushed entries never seen.
//  Overflow (macro on): add 0x7FFF_FFFF+1 -> ResultE 0x8000_0000, OverflowE=1; macro off -> OverflowE=0.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_exec_unit_if : issue-side and result-side handshake bundle for the     |
// |                    execute-stage ALU unit                                  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface alu_exec_unit_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             FlushE;
  logic             ValidD;
  logic             ReadyD;
  logic [3:0]       ALUControlD;
  logic [WIDTH-1:0] SrcAD;
  logic [WIDTH-1:0] SrcBD;
  logic [REGW-1:0]  WriteRegD;
  logic             ValidE;
  logic             ReadyE;
  logic [WIDTH-1:0] ResultE;
  logic             ZeroE;
  logic [REGW-1:0]  WriteRegE;
  logic             IllegalE;
  logic             OverflowE;

  modport master (
    output FlushE, ValidD, ALUControlD, SrcAD, SrcBD, WriteRegD, ReadyE,
    input  ReadyD, ValidE, ResultE, ZeroE, WriteRegE, IllegalE, OverflowE
  );

  modport slave (
    input  FlushE, ValidD, ALUControlD, SrcAD, SrcBD, WriteRegD, ReadyE,
    output ReadyD, ValidE, ResultE, ZeroE, WriteRegE, IllegalE, OverflowE
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_exec_unit : ALU evaluation with a 2-entry result skid FIFO toward MEM. |
// | Optional macro ALU_OVERFLOW_EN stores signed add/sub overflow per entry.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  wire             clk,
  input  wire             reset,
  alu_exec_unit_if.slave  io_bus
);
  localparam logic [1:0] C_CNT_EMPTY = 2'd0;
  localparam logic [1:0] C_CNT_ONE   = 2'd1;
  localparam logic [1:0] C_CNT_FULL  = 2'd2;

  localparam logic [3:0] C_OP_AND  = 4'b0000;
  localparam logic [3:0] C_OP_OR   = 4'b0001;
  localparam logic [3:0] C_OP_ADD  = 4'b0010;
  localparam logic [3:0] C_OP_SLT  = 4'b0011;
  localparam logic [3:0] C_OP_XOR  = 4'b0100;
  localparam logic [3:0] C_OP_NOR  = 4'b0101;
  localparam logic [3:0] C_OP_SUB  = 4'b0110;
  localparam logic [3:0] C_OP_LUI  = 4'b0111;
  localparam logic [3:0] C_OP_SLTU = 4'b1000;

  logic [1:0]       r_count;
  logic             r_wptr;
  logic             r_rptr;
  logic [WIDTH-1:0] r_res [0:1];
  logic [REGW-1:0]  r_tag [0:1];
  logic             r_ill [0:1];

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ill;

  assign w_a    = io_bus.SrcAD;
  assign w_b    = io_bus.SrcBD;
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (io_bus.ALUControlD)
      C_OP_AND:  w_res = w_a & w_b;
      C_OP_OR:   w_res = w_a | w_b;
      C_OP_ADD:  w_res = w_sum;
      C_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      C_OP_XOR:  w_res = w_a ^ w_b;
      C_OP_NOR:  w_res = ~(w_a | w_b);
      C_OP_SUB:  w_res = w_diff;
      C_OP_LUI:  w_res = w_b << 16;
      C_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      default:   w_ill = 1'b1;
    endcase
  end

  // Flush outranks both handshakes: a transfer coinciding with it never happens.
  assign w_push = io_bus.ValidD & io_bus.ReadyD & ~io_bus.FlushE;
  assign w_pop  = io_bus.ValidE & io_bus.ReadyE & ~io_bus.FlushE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= C_CNT_EMPTY;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_res[0] <= '0;
      r_res[1] <= '0;
      r_tag[0] <= '0;
      r_tag[1] <= '0;
      r_ill[0] <= 1'b0;
      r_ill[1] <= 1'b0;
    end else if (io_bus.FlushE) begin
      r_count <= C_CNT_EMPTY;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_push) begin
        r_res[r_wptr] <= w_res;
        r_tag[r_wptr] <= io_bus.WriteRegD;
        r_ill[r_wptr] <= w_ill;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic r_ovf [0:1];
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    case (io_bus.ALUControlD)
      C_OP_ADD: w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      C_OP_SUB: w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      default:  w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf[0] <= 1'b0;
      r_ovf[1] <= 1'b0;
    end else if (w_push) begin
      r_ovf[r_wptr] <= w_ovf;
    end
  end

  assign io_bus.OverflowE = r_ovf[r_rptr];
`else
  assign io_bus.OverflowE = 1'b0;
`endif

  // Handshake outputs come from registered occupancy only; no D<->E combinational path.
  assign io_bus.ReadyD    = (r_count != C_CNT_FULL);
  assign io_bus.ValidE    = (r_count != C_CNT_EMPTY);
  assign io_bus.ResultE   = r_res[r_rptr];
  assign io_bus.ZeroE     = (r_res[r_rptr] == '0);
  assign io_bus.WriteRegE = r_tag[r_rptr];
  assign io_bus.IllegalE  = r_ill[r_rptr];
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_exec_unit : scoreboard bench for alu_exec_unit (directed vectors)   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_alu_exec_unit;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t r_exp_next;

  alu_exec_unit_if #(.WIDTH(32), .REGW(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .REGW(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue-side bookkeeping: record expected results for accepted operations.
  always @(negedge clk) begin
    if (reset || bus.FlushE) begin
      sb_q.delete();
    end else if (bus.ValidD && bus.ReadyD) begin
      sb_q.push_back(r_exp_next);
    end
  end

  // Monitor: compare every result the DUT hands to the memory stage.
  always @(negedge clk) begin
    if (!reset && !bus.FlushE && bus.ValidE && bus.ReadyE) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 64'(bus.ResultE), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ResultE",   64'(bus.ResultE),   64'(e.res));
        check("ZeroE",     64'(bus.ZeroE),     64'(e.res == 32'h0));
        check("WriteRegE", 64'(bus.WriteRegE), 64'(e.tag));
        check("IllegalE",  64'(bus.IllegalE),  64'(e.ill));
        check("OverflowE", 64'(bus.OverflowE), 64'(e.ovf));
      end
    end
  end

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] res, input logic ill,
                        input logic ovf);
    bus.ValidD      = 1'b1;
    bus.ALUControlD = op;
    bus.SrcAD       = a;
    bus.SrcBD       = b;
    bus.WriteRegD   = tag;
    r_exp_next      = '{res: res, tag: tag, ill: ill, ovf: ovf};
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input logic ill,
                       input logic ovf);
    bit done = 0;
    set_op(op, a, b, tag, res, ill, ovf);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      done = bus.ReadyD;
      @(posedge clk); #1;
    end
    if (!done) check("issue_timeout", 64'd0, 64'd1);
    bus.ValidD = 1'b0;
  endtask

  localparam logic OVF_ON =
`ifdef ALU_OVERFLOW_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    bus.FlushE = 1'b0; bus.ValidD = 1'b0; bus.ReadyE = 1'b0;
    bus.ALUControlD = 4'h0; bus.SrcAD = '0; bus.SrcBD = '0; bus.WriteRegD = '0;
    r_exp_next = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ReadyD", 64'(bus.ReadyD), 64'd1);
    check("rst_ValidE", 64'(bus.ValidE), 64'd0);
    check("rst_ResultE", 64'(bus.ResultE), 64'd0);
    check("rst_ZeroE", 64'(bus.ZeroE), 64'd1);
    check("rst_WriteRegE", 64'(bus.WriteRegE), 64'd0);
    check("rst_IllegalE", 64'(bus.IllegalE), 64'd0);
    check("rst_OverflowE", 64'(bus.OverflowE), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Operation table
    bus.ReadyE = 1'b1;
    issue(4'b0000, 32'hFFFF_FFF0, 32'h10, 5'd1,  32'h0000_0010, 1'b0, 1'b0);
    issue(4'b0001, 32'hFFFF_FFF0, 32'h10, 5'd2,  32'hFFFF_FFF0, 1'b0, 1'b0);
    issue(4'b0010, 32'hFFFF_FFF0, 32'h10, 5'd3,  32'h0000_0000, 1'b0, 1'b0);
    issue(4'b0011, 32'hFFFF_FFF0, 32'h10, 5'd4,  32'h0000_0001, 1'b0, 1'b0);
    issue(4'b0100, 32'hFFFF_FFF0, 32'h10, 5'd5,  32'hFFFF_FFE0, 1'b0, 1'b0);
    issue(4'b0101, 32'hFFFF_FFF0, 32'h10, 5'd6,  32'h0000_000F, 1'b0, 1'b0);
    issue(4'b0110, 32'hFFFF_FFF0, 32'h10, 5'd7,  32'hFFFF_FFE0, 1'b0, 1'b0);
    issue(4'b0111, 32'hFFFF_FFF0, 32'h10, 5'd8,  32'h0010_0000, 1'b0, 1'b0);
    issue(4'b1000, 32'hFFFF_FFF0, 32'h10, 5'd9,  32'h0000_0000, 1'b0, 1'b0);
    issue(4'b1111, 32'hFFFF_FFF0, 32'h10, 5'd10, 32'h0000_0000, 1'b1, 1'b0);
    issue(4'b1001, 32'h1234_5678, 32'h1,  5'd11, 32'h0000_0000, 1'b1, 1'b0);
    issue(4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 5'd12, 32'h0000_0001, 1'b0, 1'b0);
    issue(4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1'b0, 1'b0);
    // Overflow cases
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd14, 32'h8000_0000, 1'b0, OVF_ON);
    issue(4'b0110, 32'h8000_0000, 32'h1, 5'd15, 32'h7FFF_FFFF, 1'b0, OVF_ON);
    issue(4'b0010, 32'h8000_0000, 32'h8000_0000, 5'd16, 32'h0, 1'b0, OVF_ON);
    repeat (2) @(posedge clk); #1;

    // Streaming: one accepted op per cycle, buffer never fills
    for (int i = 0; i < 20; i++) begin
      set_op(4'b0010, 32'(i), 32'(3 * i), 5'(i), 32'(4 * i), 1'b0, 1'b0);
      @(negedge clk);
      check("stream_ReadyD", 64'(bus.ReadyD), 64'd1);
      if (i > 0) check("stream_ValidE", 64'(bus.ValidE), 64'd1);
      @(posedge clk); #1;
    end
    bus.ValidD = 1'b0;
    @(negedge clk);
    check("stream_last_valid", 64'(bus.ValidE), 64'd1);
    @(posedge clk); #1;

    // Backpressure
    bus.ReadyE = 1'b0;
    issue(4'b0100, 32'hA5A5_0000, 32'h0000_5A5A, 5'd20, 32'hA5A5_5A5A, 1'b0, 1'b0);
    issue(4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd21, 32'h0000_0000, 1'b0, 1'b0);
    set_op(4'b0001, 32'h1, 32'h2, 5'd22, 32'h3, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_ReadyD_low", 64'(bus.ReadyD), 64'd0);
      check("bp_head_stable", 64'(bus.ResultE), 64'hA5A5_5A5A);
      check("bp_tag_stable", 64'(bus.WriteRegE), 64'd20);
      @(posedge clk); #1;
    end
    bus.ReadyE = 1'b1;
    @(negedge clk);
    check("bp_ReadyD_at_pop", 64'(bus.ReadyD), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ReadyD_after_pop", 64'(bus.ReadyD), 64'd1);
    check("bp_second_head", 64'(bus.WriteRegE), 64'd21);
    @(posedge clk); #1;
    bus.ValidD = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Flush with concurrent push and pop
    bus.ReadyE = 1'b0;
    issue(4'b0010, 32'd100, 32'd1, 5'd25, 32'd101, 1'b0, 1'b0);
    issue(4'b0010, 32'd200, 32'd2, 5'd26, 32'd202, 1'b0, 1'b0);
    set_op(4'b0010, 32'd300, 32'd3, 5'd27, 32'd303, 1'b0, 1'b0);
    bus.FlushE = 1'b1;
    bus.ReadyE = 1'b1;
    @(posedge clk); #1;
    bus.FlushE = 1'b0;
    bus.ValidD = 1'b0;
    @(negedge clk);
    check("flush_ValidE", 64'(bus.ValidE), 64'd0);
    check("flush_ReadyD", 64'(bus.ReadyD), 64'd1);
    @(posedge clk); #1;
    issue(4'b0110, 32'd50, 32'd8, 5'd28, 32'd42, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset while full
    bus.ReadyE = 1'b0;
    issue(4'b0001, 32'h00FF, 32'hFF00, 5'd29, 32'hFFFF, 1'b0, 1'b0);
    issue(4'b0001, 32'h0F00, 32'h00F0, 5'd30, 32'h0FF0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_full", 64'(bus.ReadyD), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ValidE", 64'(bus.ValidE), 64'd0);
    check("mid_rst_ReadyD", 64'(bus.ReadyD), 64'd1);
    check("mid_rst_ResultE", 64'(bus.ResultE), 64'd0);
    check("mid_rst_ZeroE", 64'(bus.ZeroE), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.ReadyE = 1'b1;
    @(posedge clk); #1;
    issue(4'b0111, 32'h0, 32'h0000_ABCD, 5'd31, 32'hABCD_0000, 1'b0, 1'b0);

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    check("final_ValidE", 64'(bus.ValidE), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
